// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time, and returns
// tagged results on a valid/ready channel. Build option: ALU_SEQ_STATS_EN adds ops_done_o.
module alu_cmd_sequencer #(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [WIDTH-1:0]            cmd_first_i,
  input  logic [WIDTH-1:0]            cmd_second_i,
  input  logic [2:0]                  cmd_opcode_i,
  input  logic [TAG_W-1:0]            cmd_tag_i,
  output logic [WIDTH-1:0]            alu_first_o,
  output logic [WIDTH-1:0]            alu_second_o,
  output logic [2:0]                  alu_opcode_o,
  input  logic [WIDTH-1:0]            alu_result_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [WIDTH-1:0]            rsp_result_o,
  output logic [2:0]                  rsp_opcode_o,
  output logic [TAG_W-1:0]            rsp_tag_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]                 ops_done_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              rdy_q;
  logic              push, pop, capture, rsp_done, empty, full;
  logic [TAG_W-1:0]  tag_p0;

  logic [WIDTH-1:0]  mem_first  [FIFO_DEPTH];
  logic [WIDTH-1:0]  mem_second [FIFO_DEPTH];
  logic [2:0]        mem_opcode [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag    [FIFO_DEPTH];

  // rdy_q keeps cmd_ready_o low through reset and depends on no response-side input
  assign full        = (fifo_count_o == FULL_CNT);
  assign empty       = (fifo_count_o == '0);
  assign cmd_ready_o = rdy_q & ~full;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign busy_o      = (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_first[wr_ptr]  <= cmd_first_i;
      mem_second[wr_ptr] <= cmd_second_i;
      mem_opcode[wr_ptr] <= cmd_opcode_i;
      mem_tag[wr_ptr]    <= cmd_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + CNT_W'(1);
        2'b01:   fifo_count_o <= fifo_count_o - CNT_W'(1);
        default: fifo_count_o <= fifo_count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_WAIT;
      S_WAIT:  if (lat_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = empty ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      S_IDLE:  pop = ~empty;
      S_WAIT:  capture = (lat_q == '0);
      S_RESP: begin
        rsp_done = rsp_ready_i;
        pop      = rsp_ready_i & ~empty;
      end
      default: ;
    endcase
  end

  // Issue stage (p0): head command drives the ALU; tag is held until capture
  always_ff @(posedge clk_i) begin
    if (pop) tag_p0 <= mem_tag[rd_ptr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_first_o  <= '0;
      alu_second_o <= '0;
      alu_opcode_o <= '0;
      lat_q        <= '0;
    end else if (pop) begin
      alu_first_o  <= mem_first[rd_ptr];
      alu_second_o <= mem_second[rd_ptr];
      alu_opcode_o <= mem_opcode[rd_ptr];
      lat_q        <= LAT_INIT;
    end else if (state_q == S_WAIT && lat_q != '0) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

  // Capture stage: ALU result is latched with its tag and held until the handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_opcode_o <= '0;
      rsp_tag_o    <= '0;
    end else if (capture) begin
      rsp_valid_o  <= 1'b1;
      rsp_result_o <= alu_result_i;
      rsp_opcode_o <= alu_opcode_o;
      rsp_tag_o    <= tag_p0;
    end else if (rsp_done) begin
      rsp_valid_o  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       ops_done_o <= '0;
    else if (rsp_done) ops_done_o <= sat_inc16(ops_done_o);
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a 1-cycle adder ALU stub.
module tb_alu_cmd_sequencer;
  localparam int WIDTH       = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int ALU_LATENCY = 1;
  localparam int TAG_W       = 4;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_first = '0;
  logic [WIDTH-1:0] cmd_second = '0;
  logic [2:0]       cmd_opcode = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [WIDTH-1:0] alu_first, alu_second, alu_result;
  logic [2:0]       alu_opcode;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_opcode;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [CW-1:0]    fifo_count;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]      ops_done;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;

  alu_cmd_sequencer #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .ALU_LATENCY(ALU_LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_first_i(cmd_first), .cmd_second_i(cmd_second),
    .cmd_opcode_i(cmd_opcode), .cmd_tag_i(cmd_tag),
    .alu_first_o(alu_first), .alu_second_o(alu_second), .alu_opcode_o(alu_opcode),
    .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_opcode_o(rsp_opcode), .rsp_tag_o(rsp_tag),
    .busy_o(busy), .fifo_count_o(fifo_count)
`ifdef ALU_SEQ_STATS_EN
    , .ops_done_o(ops_done)
`endif
  );

  always #5 clk = ~clk;

  // ALU stub: registered adder, one edge of latency
  always @(posedge clk) alu_result <= alu_first + alu_second;

  function automatic logic [WIDTH-1:0] model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH-1:0];
  endfunction

  task automatic drive_cmd(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] op, input logic [TAG_W-1:0] t);
    cmd_valid  = v;
    cmd_first  = a;
    cmd_second = b;
    cmd_opcode = op;
    cmd_tag    = t;
  endtask

  // Records the expected response for a command that the next edge will accept.
  task automatic sb_record(output bit accepted);
    exp_t e;
    accepted = 1'b0;
    if (cmd_valid && cmd_ready) begin
      e.res = model_add(cmd_first, cmd_second);
      e.op  = cmd_opcode;
      e.tag = cmd_tag;
      sb.push_back(e);
      accepted = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_cmd(1'b0, '0, '0, '0, '0);
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({alu_first, alu_second, alu_opcode, rsp_valid, rsp_result, rsp_opcode, rsp_tag, busy, fifo_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs alu=%h/%h/%h rsp=%b/%h/%h/%h busy=%b cnt=%0d, all required 0",
               alu_first, alu_second, alu_opcode, rsp_valid, rsp_result, rsp_opcode, rsp_tag, busy, fifo_count);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready);
    end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || fifo_count !== CW'(0)) begin
      failures++;
      $display("FAIL reset_release ready=%b cnt=%0d want ready=1 cnt=0", cmd_ready, fifo_count);
    end
  endtask

  task automatic test_single_op();
    bit   acc;
    exp_t e, got;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_cmd(1'b1, 8'h12, 8'h34, 3'b010, 4'd3);
    sb_record(acc);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL single_accept cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;  // P
    drive_cmd(1'b0, '0, '0, '0, '0);
    checks++;
    if (fifo_count !== CW'(1)) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", fifo_count);
    end
    @(posedge clk); #1;  // P+1
    checks++;
    if (alu_first !== 8'h12 || alu_second !== 8'h34 || alu_opcode !== 3'b010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue alu=%h/%h/%b busy=%b want 12/34/010 busy=1", alu_first, alu_second, alu_opcode, busy);
    end
    @(posedge clk); #1;  // P+2
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_rsp rsp_valid=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;  // P+3
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h46 || rsp_tag !== 4'd3 || rsp_opcode !== 3'b010) begin
      failures++;
      $display("FAIL single_rsp valid=%b res=%h tag=%0d op=%b want 1/46/3/010", rsp_valid, rsp_result, rsp_tag, rsp_opcode);
    end
    rsp_ready = 1'b1;
    if (rsp_valid && rsp_ready) begin
      checks++;
      hs_cnt++;
      got = {rsp_result, rsp_opcode, rsp_tag};
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL single_sb unexpected response %h", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL single_sb got=%h want=%h", got, e);
        end
      end
    end
    @(posedge clk); #1;  // P+4
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    bit   acc;
    bit   done = 1'b0;
    exp_t e, got;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 12) begin
        checks++;
        if (fifo_count !== CW'(4) || cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_full cnt=%0d ready=%b want 4/0", fifo_count, cmd_ready);
        end
        checks++;
        if (idx != 5 || rsp_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_blocked accepted=%0d rsp_valid=%b want 5/1", idx, rsp_valid);
        end
      end
      if (rsp_valid && !rsp_ready) begin
        checks++;
        got = {rsp_result, rsp_opcode, rsp_tag};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL bp_hold unexpected response %h", got);
        end else if (got !== sb[0]) begin
          failures++;
          $display("FAIL bp_hold got=%h want=%h", got, sb[0]);
        end
      end
      rsp_ready = (cyc >= 12);
      if (idx < 6)
        drive_cmd(1'b1, WIDTH'(idx * 16 + 1), WIDTH'(8'h20 + idx), 3'(idx), TAG_W'(8 + idx));
      else
        drive_cmd(1'b0, '0, '0, '0, '0);
      sb_record(acc);
      if (acc) idx++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        hs_cnt++;
        got = {rsp_result, rsp_opcode, rsp_tag};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL bp_sb unexpected response %h", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL bp_sb got=%h want=%h", got, e);
          end
        end
      end
      if (cyc >= 12 && idx == 6 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    drive_cmd(1'b0, '0, '0, '0, '0);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL bp_drain accepted=%0d pending=%0d want 6/0 within budget", idx, sb.size());
    end
  endtask

  task automatic test_streaming();
    int               idx = 0;
    int               nrsp = 0;
    int               last_cyc = 0;
    bit               acc;
    exp_t             e, got;
    logic [WIDTH-1:0] a [6];
    logic [WIDTH-1:0] b [6];
    for (int i = 0; i < 6; i++) begin
      a[i] = WIDTH'($urandom);
      b[i] = WIDTH'($urandom);
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      if (idx < 6)
        drive_cmd(1'b1, a[idx], b[idx], 3'(7 - idx), TAG_W'(idx));
      else
        drive_cmd(1'b0, '0, '0, '0, '0);
      sb_record(acc);
      if (acc) idx++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        hs_cnt++;
        got = {rsp_result, rsp_opcode, rsp_tag};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stream_sb unexpected response %h", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL stream_sb got=%h want=%h", got, e);
          end
        end
        if (nrsp > 0) begin
          checks++;
          if (cyc - last_cyc != ALU_LATENCY + 2) begin
            failures++;
            $display("FAIL stream_spacing got=%0d want=%0d", cyc - last_cyc, ALU_LATENCY + 2);
          end
        end
        last_cyc = cyc;
        nrsp++;
      end
      if (nrsp == 6) break;
    end
    drive_cmd(1'b0, '0, '0, '0, '0);
    checks++;
    if (nrsp != 6) begin
      failures++;
      $display("FAIL stream_count got=%0d want=6", nrsp);
    end
  endtask

  task automatic test_wrap_value();
    bit   acc;
    bit   seen = 1'b0;
    exp_t e, got;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_cmd(1'b1, 8'hFF, 8'h01, 3'b011, 4'hA);
    sb_record(acc);
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(posedge clk); #1;
      drive_cmd(1'b0, '0, '0, '0, '0);
      if (rsp_valid && rsp_ready) begin
        seen = 1'b1;
        checks++;
        hs_cnt++;
        if (rsp_result !== 8'h00) begin
          failures++;
          $display("FAIL wrap_result got=%h want=00", rsp_result);
        end
        checks++;
        got = {rsp_result, rsp_opcode, rsp_tag};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL wrap_sb unexpected response %h", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL wrap_sb got=%h want=%h", got, e);
          end
        end
      end
    end
    checks++;
    if (!seen || !acc) begin
      failures++;
      $display("FAIL wrap_timeout accepted=%b responded=%b want 1/1", acc, seen);
    end
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'(hs_cnt)) begin
      failures++;
      $display("FAIL stats_ops_done got=%0d want=%0d", ops_done, hs_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    bit acc;
    bit saw_rsp = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_cmd(1'b1, 8'h5A, 8'h0F, 3'b101, 4'h6);
    sb_record(acc);
    @(posedge clk); #1;
    drive_cmd(1'b0, '0, '0, '0, '0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || alu_first !== 8'h5A || !acc) begin
      failures++;
      $display("FAIL midrst_pre busy=%b alu_first=%h accepted=%b want 1/5a/1", busy, alu_first, acc);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, alu_first, alu_second, alu_opcode, cmd_ready, fifo_count} !== '0) begin
      failures++;
      $display("FAIL midrst_async busy=%b rsp_valid=%b alu=%h/%h/%b ready=%b cnt=%0d want all 0",
               busy, rsp_valid, alu_first, alu_second, alu_opcode, cmd_ready, fifo_count);
    end
    sb.delete();
    hs_cnt = 0;
    #3 rst_ni = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      failures++;
      $display("FAIL midrst_dropped rsp_valid seen=1 want 0");
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_count !== CW'(0)) begin
      failures++;
      $display("FAIL midrst_idle busy=%b ready=%b cnt=%0d want 0/1/0", busy, cmd_ready, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_streaming();
    test_wrap_value();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    test_reset_mid_wait();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
